// File: rtl/fg_prog_pkg.sv
// Shared types and timing defaults for the floating-gate programming-mux controller.
package fg_prog_pkg;

    typedef enum logic [1:0] {
        OP_PROG  = 2'b00,
        OP_ERASE = 2'b01,
        OP_READ  = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_STROBE = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam int unsigned DEF_PULSE_CYC  = 16;
    localparam int unsigned DEF_SETTLE_CYC = 4;

    // Cycle-counter width: enough for the longer of the two phase lengths plus one bit.
    function automatic int unsigned cyc_width(input int unsigned a, input int unsigned b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/fg_onehot_dec.sv
// Binary-to-one-hot decoder with enable; N lets the caller mask unused codes.
module fg_onehot_dec #(
    parameter int unsigned W = 4,
    parameter int unsigned N = 2 ** W
) (
    input  logic [W-1:0] addr,
    input  logic         en,
    output logic [N-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = en && (addr == W'(i));
        end
    end

endmodule

// File: rtl/fg_prog_mux_ctrl.sv
// Programming-mux sequencer for floating-gate switch islands: select decode,
// program/erase pulse timing, read strobe and abort handling.
module fg_prog_mux_ctrl
    import fg_prog_pkg::*;
#(
    parameter int unsigned NUM_ISLANDS = 2,
    parameter int unsigned ROW_W       = 4,
    parameter int unsigned COL_W       = 5,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned PULSE_CYC   = DEF_PULSE_CYC,
    parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
    localparam int unsigned ISL_W      = (NUM_ISLANDS > 1) ? $clog2(NUM_ISLANDS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [ISL_W-1:0]        cmd_island,
    input  logic [ROW_W-1:0]        cmd_row,
    input  logic [COL_W-1:0]        cmd_col,
    input  logic [CNT_W-1:0]        cmd_pulses,
    input  logic                    abort,
    output logic [NUM_ISLANDS-1:0]  island_en,
    output logic [2**ROW_W-1:0]     row_sel,
    output logic [2**COL_W-1:0]     col_sel,
    output logic                    vprog_en,
    output logic                    verase_en,
    output logic                    read_strobe,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int unsigned CYC_W = cyc_width(PULSE_CYC, SETTLE_CYC);
    localparam int unsigned NROW  = 2 ** ROW_W;
    localparam int unsigned NCOL  = 2 ** COL_W;

    state_e             state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   pulses_q, pulses_d;
    op_e                op_q, op_d;
    logic [ISL_W-1:0]   isl_q, isl_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;

    logic [NUM_ISLANDS-1:0] island_en_q, island_en_d;
    logic [NROW-1:0]        row_sel_q, row_sel_d;
    logic [NCOL-1:0]        col_sel_q, col_sel_d;
    logic                   vprog_q, vprog_d;
    logic                   verase_q, verase_d;
    logic                   strobe_q, strobe_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   isl_sel_c, rc_sel_c;

    assign cmd_ready = (state_q == ST_IDLE) && !rst;

    // Next-state, counters and field capture.
    always_comb begin
        state_d  = state_q;
        cyc_d    = (cyc_q != '0) ? cyc_q - CYC_W'(1) : cyc_q;
        pulses_d = pulses_q;
        op_d     = op_q;
        isl_d    = isl_q;
        row_d    = row_q;
        col_d    = col_q;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d     = op_e'(cmd_op);
                    isl_d    = cmd_island;
                    row_d    = cmd_row;
                    col_d    = cmd_col;
                    pulses_d = cmd_pulses;
                    if (32'(cmd_island) >= NUM_ISLANDS) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else if (op_e'(cmd_op) == OP_NOP) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else if (cyc_q == '0) begin
                    case (op_q)
                        OP_READ: state_d = ST_STROBE;
                        OP_PROG: state_d = (pulses_q == '0) ? ST_DONE : ST_PULSE;
                        default: state_d = ST_PULSE;
                    endcase
                end
            end
            ST_PULSE: begin
                if (abort) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else if (cyc_q == '0) begin
                    if (op_q == OP_PROG) begin
                        state_d = ST_GAP;
                        if (pulses_q != '0) pulses_d = pulses_q - CNT_W'(1);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else if (cyc_q == '0) begin
                    state_d = (pulses_q == '0) ? ST_DONE : ST_PULSE;
                end
            end
            ST_STROBE: begin
                state_d = ST_DONE;
                err_d   = abort;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Every state entry reloads the phase timer.
        if (state_d != state_q) begin
            case (state_d)
                ST_SETUP, ST_GAP: cyc_d = CYC_W'(SETTLE_CYC - 1);
                ST_PULSE:         cyc_d = CYC_W'(PULSE_CYC - 1);
                default:          cyc_d = '0;
            endcase
        end
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        isl_sel_c = (state_d != ST_IDLE) && (op_d != OP_NOP) && (32'(isl_d) < NUM_ISLANDS);
        rc_sel_c  = isl_sel_c && (op_d != OP_ERASE);
        vprog_d   = (state_d == ST_PULSE) && (op_d == OP_PROG);
        verase_d  = (state_d == ST_PULSE) && (op_d == OP_ERASE);
        strobe_d  = (state_d == ST_STROBE);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
    end

    fg_onehot_dec #(.W(ISL_W), .N(NUM_ISLANDS)) u_isl_dec (
        .addr   (isl_d),
        .en     (isl_sel_c),
        .onehot (island_en_d)
    );

    fg_onehot_dec #(.W(ROW_W), .N(NROW)) u_row_dec (
        .addr   (row_d),
        .en     (rc_sel_c),
        .onehot (row_sel_d)
    );

    fg_onehot_dec #(.W(COL_W), .N(NCOL)) u_col_dec (
        .addr   (col_d),
        .en     (rc_sel_c),
        .onehot (col_sel_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cyc_q       <= '0;
            pulses_q    <= '0;
            op_q        <= OP_NOP;
            isl_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            island_en_q <= '0;
            row_sel_q   <= '0;
            col_sel_q   <= '0;
            vprog_q     <= 1'b0;
            verase_q    <= 1'b0;
            strobe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            pulses_q    <= pulses_d;
            op_q        <= op_d;
            isl_q       <= isl_d;
            row_q       <= row_d;
            col_q       <= col_d;
            island_en_q <= island_en_d;
            row_sel_q   <= row_sel_d;
            col_sel_q   <= col_sel_d;
            vprog_q     <= vprog_d;
            verase_q    <= verase_d;
            strobe_q    <= strobe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign island_en   = island_en_q;
    assign row_sel     = row_sel_q;
    assign col_sel     = col_sel_q;
    assign vprog_en    = vprog_q;
    assign verase_en   = verase_q;
    assign read_strobe = strobe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fg_prog_mux_ctrl.sv
// Scoreboard bench for fg_prog_mux_ctrl: stimulus queues expected per-command
// results, a negedge monitor measures each operation and compares at done.
module tb_fg_prog_mux_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b11;
    logic [1:0]  cmd_island = '0;
    logic [3:0]  cmd_row = '0;
    logic [4:0]  cmd_col = '0;
    logic [7:0]  cmd_pulses = '0;
    logic        abort = 1'b0;
    logic [2:0]  island_en;
    logic [15:0] row_sel;
    logic [31:0] col_sel;
    logic        vprog_en, verase_en, read_strobe, busy, done, err;

    always #5 clk = ~clk;

    fg_prog_mux_ctrl #(
        .NUM_ISLANDS (3),
        .ROW_W       (4),
        .COL_W       (5),
        .CNT_W       (8),
        .PULSE_CYC   (16),
        .SETTLE_CYC  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_island  (cmd_island),
        .cmd_row     (cmd_row),
        .cmd_col     (cmd_col),
        .cmd_pulses  (cmd_pulses),
        .abort       (abort),
        .island_en   (island_en),
        .row_sel     (row_sel),
        .col_sel     (col_sel),
        .vprog_en    (vprog_en),
        .verase_en   (verase_en),
        .read_strobe (read_strobe),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    typedef struct {
        int          lat;
        bit          err;
        logic [2:0]  isl;
        logic [15:0] row;
        logic [31:0] col;
        int          pcnt;
        int          ecnt;
        int          rises;
        int          first;
        int          scnt;
        int          soff;
        int          delta;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int lat, input bit e, input logic [2:0] isl,
                                input logic [15:0] row, input logic [31:0] col,
                                input int pcnt, input int ecnt, input int rises, input int first,
                                input int scnt, input int soff, input int delta);
        exp_t x;
        x.lat = lat; x.err = e; x.isl = isl; x.row = row; x.col = col;
        x.pcnt = pcnt; x.ecnt = ecnt; x.rises = rises; x.first = first;
        x.scnt = scnt; x.soff = soff; x.delta = delta;
        return x;
    endfunction

    // Monitor: tracks the operation in flight and compares against the queue head.
    bit active = 0, post = 0, both = 0, sel_bad = 0, prev_pulse = 0;
    int acc = 0, last_acc = -1000, delta = 0;
    int pcnt = 0, ecnt = 0, rises = 0, first = -1, scnt = 0, soff = -1;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0;
                post   = 0;
            end else begin
                if (post) begin
                    check("post_done_island", 64'(island_en), 64'(0));
                    check("post_done_rowcol", 64'({row_sel, col_sel}), 64'(0));
                    check("post_done_ready", 64'(cmd_ready), 64'(1));
                    post = 0;
                end
                if (active) begin
                    if (vprog_en) pcnt++;
                    if (verase_en) ecnt++;
                    if (vprog_en && verase_en) both = 1;
                    if ((vprog_en || verase_en) && !prev_pulse) begin
                        rises++;
                        if (first < 0) first = cyc - acc;
                    end
                    prev_pulse = vprog_en || verase_en;
                    if (read_strobe) begin
                        scnt++;
                        soff = cyc - acc;
                    end
                    if (sb.size() > 0 && cyc > acc) begin
                        if (island_en !== sb[0].isl || row_sel !== sb[0].row || col_sel !== sb[0].col)
                            sel_bad = 1;
                    end
                    if (done) begin
                        if (sb.size() == 0) begin
                            n_cmp++; n_bad++;
                            $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
                        end else begin
                            e = sb.pop_front();
                            check("done_latency", 64'(cyc - acc), 64'(e.lat));
                            check("err", 64'(err), 64'(e.err));
                            check("busy_at_done", 64'(busy), 64'(1));
                            check("island_en", 64'(island_en), 64'(e.isl));
                            check("row_sel", 64'(row_sel), 64'(e.row));
                            check("col_sel", 64'(col_sel), 64'(e.col));
                            check("sel_stable", 64'(sel_bad), 64'(0));
                            check("vprog_cycles", 64'(pcnt), 64'(e.pcnt));
                            check("verase_cycles", 64'(ecnt), 64'(e.ecnt));
                            check("pulse_runs", 64'(rises), 64'(e.rises));
                            check("first_pulse", 64'(first), 64'(e.first));
                            check("strobe_cycles", 64'(scnt), 64'(e.scnt));
                            check("strobe_offset", 64'(soff), 64'(e.soff));
                            check("enables_exclusive", 64'(both), 64'(0));
                            if (e.delta >= 0) check("accept_spacing", 64'(delta), 64'(e.delta));
                        end
                        active = 0;
                        post   = 1;
                    end
                end else if (done) begin
                    n_cmp++; n_bad++;
                    $display("FAIL stray_done: got done=1 while idle (cycle %0d)", cyc);
                end
                if (cmd_valid && cmd_ready) begin
                    active = 1;
                    delta = cyc - last_acc;
                    last_acc = cyc;
                    acc = cyc;
                    pcnt = 0; ecnt = 0; rises = 0; first = -1; scnt = 0; soff = -1;
                    both = 0; sel_bad = 0; prev_pulse = 0;
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input int isl, input int row, input int col,
                        input int pulses, input bit hold);
        bit acc_ok = 0;
        int n = 0;
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_island = 2'(isl);
        cmd_row    = 4'(row);
        cmd_col    = 5'(col);
        cmd_pulses = 8'(pulses);
        while (!acc_ok && n < 300) begin
            @(negedge clk);
            acc_ok = cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hold) cmd_valid = 1'b0;
        if (!acc_ok) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got no accept in %0d cycles expected accept", n);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'({island_en, vprog_en, verase_en, read_strobe, busy, done, err, cmd_ready}), 64'(0));
        check({name, "_sel"}, 64'({row_sel, col_sel}), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_outputs");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(cmd_ready), 64'(1));
        check("busy_after_reset", 64'(busy), 64'(0));
        @(posedge clk); #1;

        // PROG island 1, row 3, col 17, three pulses
        sb.push_back(mk(65, 0, 3'b010, 16'h0008, 32'h0002_0000, 48, 0, 3, 5, 0, -1, -1));
        send(2'b00, 1, 3, 17, 3, 0);

        // ERASE island 0: island select only
        sb.push_back(mk(21, 0, 3'b001, 16'h0000, 32'h0000_0000, 0, 16, 1, 5, 0, -1, -1));
        send(2'b01, 0, 5, 9, 7, 0);

        // READ row 15, col 31 with valid held; NOP follows back-to-back
        sb.push_back(mk(6, 0, 3'b001, 16'h8000, 32'h8000_0000, 0, 0, 0, -1, 1, 5, -1));
        send(2'b10, 0, 15, 31, 0, 1);
        sb.push_back(mk(1, 0, 3'b000, 16'h0000, 32'h0000_0000, 0, 0, 0, -1, 0, -1, 7));
        send(2'b11, 1, 2, 3, 0, 0);

        // Island index equal to NUM_ISLANDS is illegal
        sb.push_back(mk(1, 1, 3'b000, 16'h0000, 32'h0000_0000, 0, 0, 0, -1, 0, -1, -1));
        send(2'b00, 3, 3, 17, 3, 0);

        // PROG with zero pulses on the top island
        sb.push_back(mk(5, 0, 3'b100, 16'h0002, 32'h0000_0004, 0, 0, 0, -1, 0, -1, -1));
        send(2'b00, 2, 1, 2, 0, 0);

        // Abort during the first PROG pulse
        sb.push_back(mk(11, 1, 3'b001, 16'h0001, 32'h0000_0001, 6, 0, 1, 5, 0, -1, -1));
        send(2'b00, 0, 0, 0, 2, 0);
        repeat (9) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;

        // abort while idle and through DONE is ignored
        abort = 1'b1;
        sb.push_back(mk(1, 0, 3'b000, 16'h0000, 32'h0000_0000, 0, 0, 0, -1, 0, -1, -1));
        send(2'b11, 0, 0, 0, 0, 0);
        @(posedge clk); #1 abort = 1'b0;

        // Reset in the first GAP: everything drops, no done
        send(2'b00, 1, 2, 4, 3, 0);
        repeat (21) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_all_zero("midop_reset_outputs");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_midop_reset", 64'(cmd_ready), 64'(1));
        check("busy_after_midop_reset", 64'(busy), 64'(0));
        @(posedge clk); #1;

        // Recovery READ on island 2
        sb.push_back(mk(6, 0, 3'b100, 16'h0001, 32'h0000_0001, 0, 0, 0, -1, 1, 5, -1));
        send(2'b10, 2, 0, 0, 0, 0);

        w = 0;
        while (sb.size() > 0 && w < 500) begin
            @(posedge clk);
            w++;
        end
        if (sb.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL pending_results: got %0d outstanding expected 0", sb.size());
        end
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
